// File: rtl/alu_executor.sv
// alu_executor: RV32I-style ALU with a valid/ready handshake on both sides.
// Single-cycle ops (add, sub, and, or, xor, slt, sltu) and iterative
// one-bit-per-cycle shifts (sll, srl, sra). Unsupported codes complete with
// result 0 and illegal set.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     operation handshake (in_ready only while idle)
//   alu_control             4-bit operation code from the ALU decoder
//   operand_a, operand_b    source operands (operand_b[4:0] is the shamt)
//   out_valid / out_ready   result handshake (out_valid only while done)
//   result, zero, illegal   operation result and flags, held until taken
module alu_executor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int unsigned SHAMT_W = 5;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL0 = 4'b0100;
    localparam logic [3:0] OP_SLL1 = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1111;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SH_NONE = 2'd0,
        SH_LL   = 2'd1,
        SH_RL   = 2'd2,
        SH_RA   = 2'd3
    } shift_t;

    state_t               state_q, state_d;
    shift_t               shift_q, shift_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 ill_q, ill_d;
    logic [WIDTH-1:0]     result_d;
    logic                 zero_d;
    logic                 illegal_d;
    logic                 in_ready_d;
    logic                 out_valid_d;

    logic [WIDTH-1:0]     op_value;
    shift_t               op_shift;
    logic                 op_illegal;
    logic [WIDTH-1:0]     shifted;

    // Operation decode and single-cycle datapath
    always_comb begin
        op_value   = '0;
        op_shift   = SH_NONE;
        op_illegal = 1'b0;
        case (alu_control)
            OP_ADD:           op_value = operand_a + operand_b;
            OP_SUB:           op_value = operand_a - operand_b;
            OP_AND:           op_value = operand_a & operand_b;
            OP_OR:            op_value = operand_a | operand_b;
            OP_XOR:           op_value = operand_a ^ operand_b;
            OP_SLT:           op_value = WIDTH'($signed(operand_a) < $signed(operand_b));
            OP_SLTU:          op_value = WIDTH'(operand_a < operand_b);
            OP_SLL0, OP_SLL1: op_shift = SH_LL;
            OP_SRL:           op_shift = SH_RL;
            OP_SRA:           op_shift = SH_RA;
            default:          op_illegal = 1'b1;
        endcase
    end

    // One-bit shift step of the working register
    always_comb begin
        case (shift_q)
            SH_LL:   shifted = {acc_q[WIDTH-2:0], 1'b0};
            SH_RL:   shifted = {1'b0, acc_q[WIDTH-1:1]};
            SH_RA:   shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
            default: shifted = acc_q;
        endcase
    end

    // Next-state and next-output logic. Every accepted op passes through
    // SHIFT at least once, so non-shift ops and shamt 0 share the one-cycle
    // latency of shamt 1; shamt n >= 1 finishes on the n-th shift step.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ill_d     = ill_q;
        result_d  = result;
        zero_d    = zero;
        illegal_d = illegal;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                    shift_d = op_shift;
                    ill_d   = op_illegal;
                    if (op_shift != SH_NONE) begin
                        acc_d = operand_a;
                        cnt_d = operand_b[SHAMT_W-1:0];
                    end else begin
                        acc_d = op_value;
                        cnt_d = '0;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    acc_d = shifted;
                    cnt_d = cnt_q - SHAMT_W'(1);
                end
                if (cnt_q <= SHAMT_W'(1)) begin
                    state_d   = DONE;
                    result_d  = acc_d;
                    zero_d    = (acc_d == '0);
                    illegal_d = ill_q;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= SH_NONE;
            cnt_q     <= '0;
            acc_q     <= '0;
            ill_q     <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ill_q     <= ill_d;
            result    <= result_d;
            zero      <= zero_d;
            illegal   <= illegal_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_executor.sv
// tb_alu_executor: directed literal checks plus randomized traffic checked
// every cycle against a transaction-level reference model.
module tb_alu_executor;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    int n_tests = 0;
    int n_fail  = 0;

    alu_executor #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {illegal, result} straight from the opcode table
    function automatic logic [32:0] ref_op(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        int sh;
        sa = a;
        sb = b;
        sh = int'(b[4:0]);
        case (c)
            4'b0000: return {1'b0, a + b};
            4'b0001: return {1'b0, a - b};
            4'b0010: return {1'b0, a & b};
            4'b0011: return {1'b0, a | b};
            4'b0111: return {1'b0, a ^ b};
            4'b0101: return {1'b0, (sa < sb) ? 32'd1 : 32'd0};
            4'b0110: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            4'b0100, 4'b1001: return {1'b0, a << sh};
            4'b1111: return {1'b0, a >> sh};
            4'b1101: return {1'b0, 32'(sa >>> sh)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    // Edges from accept to out_valid: shamt for shifts, never below one
    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'b0100 || c == 4'b1001 || c == 4'b1111 || c == 4'b1101)
            return (b[4:0] == 5'd0) ? 1 : int'(b[4:0]);
        return 1;
    endfunction

    // Transaction model: 0 = free, 1 = op in flight, 2 = result offered
    int          m_phase = 0;
    int          m_wait  = 0;
    logic [31:0] m_res   = 32'd0;
    logic        m_ill   = 1'b0;
    logic [32:0] m_pend  = 33'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_wait  = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_pend  = ref_op(alu_control, operand_a, operand_b);
                m_wait  = ref_lat(alu_control, operand_b);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_wait--;
            if (m_wait == 0) begin
                m_phase = 2;
                m_res   = m_pend[31:0];
                m_ill   = m_pend[32];
            end
        end else if (out_ready) begin
            m_phase = 0;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
            chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("result", result, m_res);
                chk("zero", 32'(zero), 32'(m_res == 32'd0));
                chk("illegal", 32'(illegal), 32'(m_ill));
            end
        end
    end

    task automatic wait_ready();
        int g;
        g = 0;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Issue one op at a negedge, scramble inputs after accept, check literals
    task automatic do_op(input string nm, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input logic ei,
                         input int el);
        int lat;
        wait_ready();
        alu_control = c;
        operand_a   = a;
        operand_b   = b;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        operand_a   = $urandom;
        operand_b   = $urandom;
        wait_valid(lat);
        chk({nm, "_lat"}, 32'(lat), 32'(el));
        chk({nm, "_res"}, result, er);
        chk({nm, "_zero"}, 32'(zero), 32'(er == 32'd0));
        chk({nm, "_ill"}, 32'(illegal), 32'(ei));
    endtask

    initial begin
        int lat;
        int seen;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        alu_control = 4'd0;
        operand_a   = 32'd0;
        operand_b   = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First accept right on the first edge after release
        do_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1);
        do_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 1'b0, 1);
        do_op("sltu", 4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b0, 1);
        do_op("sra31", 4'b1101, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 1'b0, 31);
        do_op("srl31", 4'b1111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 31);
        do_op("sll_sh0", 4'b1001, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1);
        do_op("sll_sh3", 4'b0100, 32'h0000_0001, 32'h0000_0003, 32'h0000_0008, 1'b0, 3);
        do_op("sra_sh1", 4'b1101, 32'hF000_0001, 32'hFFFF_FFE1, 32'hF800_0000, 1'b0, 1);
        do_op("sub", 4'b0001, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1);
        do_op("xor", 4'b0111, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1'b0, 1);
        do_op("illegal", 4'b1000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1);

        // Backpressure: result held, second op waits for the handshake
        @(negedge clk);
        out_ready = 1'b0;
        wait_ready();
        alu_control = 4'b0000;
        operand_a   = 32'd5;
        operand_b   = 32'd7;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_control = 4'b0001;
        operand_a   = 32'd100;
        operand_b   = 32'd1;
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_res", result, 32'd12);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_released_valid", 32'(out_valid), 32'd0);
        chk("bp_released_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        chk("bp_second_lat", 32'(lat), 32'd1);
        chk("bp_second_res", result, 32'd99);

        // Reset in the middle of a 20-step shift
        @(negedge clk);
        wait_ready();
        alu_control = 4'b1111;
        operand_a   = 32'hDEAD_BEEF;
        operand_b   = 32'd20;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);
        do_op("after_rst", 4'b0010, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 1'b0, 1);

        // Randomized traffic, judged by the model on every cycle
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            in_valid    = ($urandom_range(0, 2) != 0);
            alu_control = 4'($urandom_range(0, 15));
            operand_a   = $urandom;
            operand_b   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
            out_ready   = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
